// File: rtl/ca_cmd_assembler.sv
// ca_cmd_assembler: host CA command front end.
// Samples the host CA bus and chip-selects on every clock. It assembles one- or two-beat
// commands and queues only complete commands in a small FIFO. Queued commands are presented
// beat-by-beat with valid/ready to the CA distributor.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            capture enable (FIFO drains regardless)
//   cs_n, ca_raw      host chip-selects (active low) and CA bus
//   ca_out, ca_valid_out, ca_rank_out, ca_last_out, ca_ready_in   beat output handshake
//   overflow_clr      clears overflow_flag
//   fifo_level, cmd_count, drop_count, proto_err_count, overflow_flag   status
module ca_cmd_assembler #(
  parameter int unsigned CA_WIDTH   = 14,
  parameter int unsigned RANK_BITS  = 2,
  parameter int unsigned NUM_CS     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_CS-1:0]    cs_n,
  input  logic [CA_WIDTH-1:0]  ca_raw,
  output logic [CA_WIDTH-1:0]  ca_out,
  output logic                 ca_valid_out,
  output logic [RANK_BITS-1:0] ca_rank_out,
  output logic                 ca_last_out,
  input  logic                 ca_ready_in,
  input  logic                 overflow_clr,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [31:0]          cmd_count,
  output logic [15:0]          drop_count,
  output logic [15:0]          proto_err_count,
  output logic                 overflow_flag
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StBeat2} state_e;

  state_e               state_q, state_d;
  logic [CA_WIDTH-1:0]  hold_beat_q, hold_beat_d;
  logic [RANK_BITS-1:0] hold_rank_q, hold_rank_d;

  logic [CA_WIDTH-1:0]  b0_mem   [FIFO_DEPTH];
  logic [CA_WIDTH-1:0]  b1_mem   [FIFO_DEPTH];
  logic [RANK_BITS-1:0] rank_mem [FIFO_DEPTH];
  logic                 len2_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     count_q;
  logic                 beat_sel_q;

  logic [31:0] cmd_q;
  logic [15:0] drop_q, err_q;
  logic        ovf_q;

  // Capture decode
  int                   n_low;
  logic [RANK_BITS-1:0] rank_dec;
  logic                 first_eval;
  logic                 push, push_len2;
  logic [CA_WIDTH-1:0]  push_b0, push_b1;
  logic [RANK_BITS-1:0] push_rank;
  logic [1:0]           err_inc;

  always_comb begin
    n_low    = $countones(~cs_n);
    rank_dec = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (!cs_n[i]) rank_dec = RANK_BITS'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_beat_d = hold_beat_q;
    hold_rank_d = hold_rank_q;
    first_eval  = 1'b0;
    push        = 1'b0;
    push_len2   = 1'b0;
    push_b0     = '0;
    push_b1     = '0;
    push_rank   = '0;
    err_inc     = 2'd0;
    if (!enable) begin
      // Partial command silently discarded.
      state_d = StIdle;
    end else begin
      first_eval = 1'b1;
      if (state_q == StBeat2) begin
        state_d = StIdle;
        if (n_low == 0) begin
          push       = 1'b1;
          push_len2  = 1'b1;
          push_b0    = hold_beat_q;
          push_b1    = ca_raw;
          push_rank  = hold_rank_q;
          first_eval = 1'b0;
        end else begin
          // Abort, then re-evaluate this cycle as a fresh first beat.
          err_inc = 2'd1;
        end
      end
      if (first_eval && n_low == 1) begin
        if (ca_raw[1]) begin
          push      = 1'b1;
          push_b0   = ca_raw;
          push_rank = rank_dec;
        end else begin
          state_d     = StBeat2;
          hold_beat_d = ca_raw;
          hold_rank_d = rank_dec;
        end
      end else if (first_eval && n_low > 1) begin
        err_inc = err_inc + 2'd1;
      end
    end
  end

  // Output side
  logic empty, full, xfer, pop, push_ok, drop;
  logic [16:0] err_sum;

  assign empty        = (count_q == '0);
  assign full         = (count_q == LVL_W'(FIFO_DEPTH));
  assign ca_valid_out = !empty;
  assign ca_out       = empty ? '0 : (beat_sel_q ? b1_mem[rd_ptr_q] : b0_mem[rd_ptr_q]);
  assign ca_rank_out  = empty ? '0 : rank_mem[rd_ptr_q];
  assign ca_last_out  = !empty && (!len2_mem[rd_ptr_q] || beat_sel_q);
  assign xfer         = ca_valid_out && ca_ready_in;
  assign pop          = xfer && ca_last_out;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok      = push && (!full || pop);
  assign drop         = push && full && !pop;
  assign err_sum      = {1'b0, err_q} + 17'(err_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_beat_q <= '0;
      hold_rank_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_sel_q  <= 1'b0;
      cmd_q       <= '0;
      drop_q      <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_beat_q <= hold_beat_d;
      hold_rank_q <= hold_rank_d;
      if (push_ok) begin
        b0_mem[wr_ptr_q]   <= push_b0;
        b1_mem[wr_ptr_q]   <= push_b1;
        rank_mem[wr_ptr_q] <= push_rank;
        len2_mem[wr_ptr_q] <= push_len2;
        wr_ptr_q           <= wr_ptr_q + AW'(1);
        cmd_q              <= cmd_q + 32'd1;
      end
      if (xfer) begin
        beat_sel_q <= !ca_last_out;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + LVL_W'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - LVL_W'(1);
      end
      if (drop && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
      err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      // Set has priority over clear.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (overflow_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign fifo_level      = count_q;
  assign cmd_count       = cmd_q;
  assign drop_count      = drop_q;
  assign proto_err_count = err_q;
  assign overflow_flag   = ovf_q;

endmodule

// File: tb/tb_ca_cmd_assembler.sv
// Directed bench for ca_cmd_assembler: a vector table plus hand-written multi-cycle sequences.
module tb_ca_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  cs_n;
  logic [13:0] ca_raw;
  logic [13:0] ca_out;
  logic        ca_valid_out;
  logic [1:0]  ca_rank_out;
  logic        ca_last_out;
  logic        ca_ready_in;
  logic        overflow_clr;
  logic [2:0]  fifo_level;
  logic [31:0] cmd_count;
  logic [15:0] drop_count;
  logic [15:0] proto_err_count;
  logic        overflow_flag;

  int checks = 0;
  int failures = 0;

  ca_cmd_assembler dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .cs_n            (cs_n),
    .ca_raw          (ca_raw),
    .ca_out          (ca_out),
    .ca_valid_out    (ca_valid_out),
    .ca_rank_out     (ca_rank_out),
    .ca_last_out     (ca_last_out),
    .ca_ready_in     (ca_ready_in),
    .overflow_clr    (overflow_clr),
    .fifo_level      (fifo_level),
    .cmd_count       (cmd_count),
    .drop_count      (drop_count),
    .proto_err_count (proto_err_count),
    .overflow_flag   (overflow_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  cs;
    logic [13:0] raw;
    logic        rdy;
    logic        ev;
    logic [13:0] eo;
    logic [1:0]  er;
    logic        el;
    logic [2:0]  elv;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [13:0] o,
                         input logic [1:0] r, input logic l);
    chk({tag, ".valid"}, 32'(ca_valid_out), 32'(v));
    chk({tag, ".out"}, 32'(ca_out), 32'(o));
    chk({tag, ".rank"}, 32'(ca_rank_out), 32'(r));
    chk({tag, ".last"}, 32'(ca_last_out), 32'(l));
  endtask

  task automatic idle_in();
    cs_n   = 4'b1111;
    ca_raw = '0;
  endtask

  logic [13:0] exp_data [4];
  logic [1:0]  exp_rank [4];

  initial begin
    rst = 1'b1; enable = 1'b1; cs_n = 4'b1111; ca_raw = '0;
    ca_ready_in = 1'b1; overflow_clr = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 14'h0, 2'd0, 1'b0);
    chk("reset.level", 32'(fifo_level), 32'd0);
    chk("reset.cmd", cmd_count, 32'd0);
    chk("reset.drop", 32'(drop_count), 32'd0);
    chk("reset.err", 32'(proto_err_count), 32'd0);
    chk("reset.ovf", 32'(overflow_flag), 32'd0);
    rst = 1'b0;

    //           en    cs       raw       rdy   ev    eo        er    el    elv
    vecs[0]  = '{1'b1, 4'b1111, 14'h0000, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 4'b1101, 14'h0002, 1'b1, 1'b1, 14'h0002, 2'd1, 1'b1, 3'd1};
    vecs[2]  = '{1'b1, 4'b1111, 14'h0000, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[3]  = '{1'b1, 4'b1110, 14'h0000, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[4]  = '{1'b1, 4'b1111, 14'h3ABC, 1'b1, 1'b1, 14'h0000, 2'd0, 1'b0, 3'd1};
    vecs[5]  = '{1'b1, 4'b1111, 14'h0000, 1'b1, 1'b1, 14'h3ABC, 2'd0, 1'b1, 3'd1};
    vecs[6]  = '{1'b1, 4'b1111, 14'h0000, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[7]  = '{1'b1, 4'b1100, 14'h0002, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[8]  = '{1'b1, 4'b1110, 14'h0000, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[9]  = '{1'b1, 4'b1011, 14'h0002, 1'b1, 1'b1, 14'h0002, 2'd2, 1'b1, 3'd1};
    vecs[10] = '{1'b1, 4'b1111, 14'h0000, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[11] = '{1'b0, 4'b1101, 14'h0002, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[12] = '{1'b1, 4'b0111, 14'h0000, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[13] = '{1'b0, 4'b1111, 14'h1234, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[14] = '{1'b1, 4'b1111, 14'h1234, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[15] = '{1'b1, 4'b1110, 14'h0000, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};
    vecs[16] = '{1'b1, 4'b1100, 14'h0000, 1'b1, 1'b0, 14'h0000, 2'd0, 1'b0, 3'd0};

    foreach (vecs[i]) begin
      enable = vecs[i].en; cs_n = vecs[i].cs; ca_raw = vecs[i].raw; ca_ready_in = vecs[i].rdy;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].er, vecs[i].el);
      chk($sformatf("vec%0d.level", i), 32'(fifo_level), 32'(vecs[i].elv));
    end
    enable = 1'b1;
    idle_in();
    tick();
    chk("table.cmd", cmd_count, 32'd3);
    chk("table.err", 32'(proto_err_count), 32'd4);
    chk("table.drop", 32'(drop_count), 32'd0);

    // Overflow: five singles with no ready.
    ca_ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cs_n = 4'b1110; ca_raw = 14'(i * 256 + 2);
      tick();
    end
    idle_in();
    chk("ovf.level", 32'(fifo_level), 32'd4);
    chk("ovf.drop", 32'(drop_count), 32'd1);
    chk("ovf.flag", 32'(overflow_flag), 32'd1);
    chk("ovf.cmd", cmd_count, 32'd7);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("ovf.clr", 32'(overflow_flag), 32'd0);
    // Drop and clear in the same cycle: set wins.
    cs_n = 4'b1110; ca_raw = 14'h0602; overflow_clr = 1'b1;
    tick();
    idle_in(); overflow_clr = 1'b0;
    chk("ovf.setwins", 32'(overflow_flag), 32'd1);
    chk("ovf.drop2", 32'(drop_count), 32'd2);
    tick();
    chk("ovf.sticky", 32'(overflow_flag), 32'd1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("ovf.clr2", 32'(overflow_flag), 32'd0);
    chk_out("stall0", 1'b1, 14'h0102, 2'd0, 1'b1);
    tick();
    chk_out("stall1", 1'b1, 14'h0102, 2'd0, 1'b1);
    // Full FIFO with simultaneous pop accepts the push.
    ca_ready_in = 1'b1; cs_n = 4'b1101; ca_raw = 14'h0702;
    tick();
    idle_in();
    chk("fullpop.level", 32'(fifo_level), 32'd4);
    chk("fullpop.drop", 32'(drop_count), 32'd2);
    chk("fullpop.cmd", cmd_count, 32'd8);
    exp_data[0] = 14'h0202; exp_data[1] = 14'h0302; exp_data[2] = 14'h0402; exp_data[3] = 14'h0702;
    exp_rank[0] = 2'd0; exp_rank[1] = 2'd0; exp_rank[2] = 2'd0; exp_rank[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("drain%0d", i), 1'b1, exp_data[i], exp_rank[i], 1'b1);
      tick();
    end
    chk_out("drained", 1'b0, 14'h0, 2'd0, 1'b0);
    chk("drained.level", 32'(fifo_level), 32'd0);

    // Two-beat command held by backpressure.
    ca_ready_in = 1'b0;
    cs_n = 4'b1011; ca_raw = 14'h0000; tick();
    cs_n = 4'b1111; ca_raw = 14'h1555; tick();
    idle_in();
    chk_out("tb_stall0", 1'b1, 14'h0000, 2'd2, 1'b0);
    tick();
    chk_out("tb_stall1", 1'b1, 14'h0000, 2'd2, 1'b0);
    ca_ready_in = 1'b1; tick(); ca_ready_in = 1'b0;
    chk_out("tb_stall2", 1'b1, 14'h1555, 2'd2, 1'b1);
    tick();
    chk_out("tb_stall3", 1'b1, 14'h1555, 2'd2, 1'b1);
    ca_ready_in = 1'b1; tick();
    chk_out("tb_done", 1'b0, 14'h0, 2'd0, 1'b0);

    // Reset mid two-beat with a queued command.
    ca_ready_in = 1'b0;
    cs_n = 4'b1110; ca_raw = 14'h0402; tick();
    cs_n = 4'b1110; ca_raw = 14'h0000; tick();
    rst = 1'b1; cs_n = 4'b1111; ca_raw = 14'h3ABC; tick();
    rst = 1'b0; idle_in();
    chk_out("rstmid", 1'b0, 14'h0, 2'd0, 1'b0);
    chk("rstmid.level", 32'(fifo_level), 32'd0);
    chk("rstmid.cmd", cmd_count, 32'd0);
    chk("rstmid.err", 32'(proto_err_count), 32'd0);
    chk("rstmid.drop", 32'(drop_count), 32'd0);
    tick();
    chk("rstmid.novalid", 32'(ca_valid_out), 32'd0);
    ca_ready_in = 1'b1; cs_n = 4'b1101; ca_raw = 14'h0002; tick();
    idle_in();
    chk_out("post_rst", 1'b1, 14'h0002, 2'd1, 1'b1);
    chk("post_rst.cmd", cmd_count, 32'd1);
    tick();
    chk("post_rst.empty", 32'(ca_valid_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
